// File: rtl/apb_m.sv
// rtl/apb_m.sv - APB requester: one command -> one SETUP/ACCESS transfer with wait-state timeout
module apb_m #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Count value seen on the last permitted ACCESS cycle before abort.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              w_accept;
  logic              w_done;
  logic              w_tmo;
  logic              w_bad;

  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pslverr only matters on the completing edge of a selected, enabled transfer.
        if (r_psel && r_penable && pready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_bad       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_cnt         <= '0;
      r_paddr       <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_paddr   <= cmd_addr;
        r_pwdata  <= cmd_wdata;
        r_pwrite  <= cmd_write;
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
        r_cnt     <= '0;
      end
      if (r_state == ST_SETUP) begin
        r_penable <= 1'b1;
      end
      if (r_state == ST_ACCESS) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_psel        <= 1'b0;
        r_penable     <= 1'b0;
        r_rsp_valid   <= 1'b1;
        r_rsp_err     <= pslverr;
        r_rsp_timeout <= 1'b0;
        r_rsp_rdata   <= (!r_pwrite && !pslverr) ? prdata : '0;
      end
      if (w_tmo) begin
        r_psel        <= 1'b0;
        r_penable     <= 1'b0;
        r_rsp_valid   <= 1'b1;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
        r_rsp_rdata   <= '0;
      end
      if (w_bad) begin
        r_psel    <= 1'b0;
        r_penable <= 1'b0;
      end
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign paddr       = r_paddr;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_m.sv
// tb/tb_apb_m.sv - directed vector bench for apb_m
module tb_apb_m;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  pwdata;
  logic [7:0]  prdata;
  logic        pready;
  logic        pslverr;

  int n_pass = 0;
  int n_total = 0;

  always #5 pclk = ~pclk;

  apb_m #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    int          waits;
    logic        slverr;
    logic [7:0]  prd;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_acc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    int lat;
    bit got;
    bit stable;
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge pclk);
    cmd_valid = 1'b0;
    chk("setup_phase", {psel, penable}, 2'b10);
    chk("setup_paddr", paddr, v.addr);
    chk("setup_pwrite", pwrite, v.wr);
    if (v.wr) chk("setup_pwdata", pwdata, v.wdata);
    k = 0; lat = 1; got = 0; stable = 1;
    for (int c = 0; c < 40 && !got; c++) begin
      if (psel && penable) begin
        k++;
        if (paddr !== v.addr || pwrite !== v.wr) stable = 0;
        pready  = (k > v.waits);
        pslverr = pready ? v.slverr : 1'b1;
        prdata  = pready ? v.prd : ~v.prd;
      end else begin
        pready = 1'b0;
      end
      @(negedge pclk);
      lat++;
      if (rsp_valid) got = 1;
    end
    pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
    chk("rsp_seen", got, 1);
    chk("access_cycles", k, v.exp_acc);
    chk("latency", lat, 2 + v.exp_acc);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("rsp_timeout", rsp_timeout, v.exp_tmo);
    chk("bus_released", {psel, penable}, 2'b00);
    chk("addr_stable", stable, 1);
    chk("ready_again", cmd_ready, 1);
    @(negedge pclk);
    chk("rsp_pulse", rsp_valid, 0);
    chk("rsp_hold", {rsp_err, rsp_timeout, rsp_rdata}, {v.exp_err, v.exp_tmo, v.exp_rdata});
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0005, 8'hA5, 0,  1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h0000_0005, 8'h00, 0,  1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1};
    vecs[2] = '{1'b0, 32'h0000_0020, 8'h00, 0,  1'b1, 8'h77, 8'h00, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 32'h0000_0008, 8'h00, 3,  1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0, 4};
    vecs[4] = '{1'b1, 32'h0000_0010, 8'h5A, 3,  1'b1, 8'h99, 8'h00, 1'b1, 1'b0, 4};
    vecs[5] = '{1'b0, 32'h0000_0040, 8'h00, 99, 1'b0, 8'hEE, 8'h00, 1'b1, 1'b1, 16};
    vecs[6] = '{1'b0, 32'hFFFF_FFFC, 8'h00, 15, 1'b0, 8'h81, 8'h81, 1'b0, 1'b0, 16};
    vecs[7] = '{1'b1, 32'h0000_0007, 8'hFF, 0,  1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1};

    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    chk("reset_bus", {psel, penable, pwrite}, 3'b000);
    chk("reset_paddr", paddr, 0);
    chk("reset_pwdata", pwdata, 0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    chk("reset_ready", cmd_ready, 1);
    preset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset mid-ACCESS with a second command held pending.
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; cmd_wdata = 8'h00;
    @(negedge pclk);
    cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 8'h3C;
    chk("busy_not_ready", cmd_ready, 0);
    chk("busy_paddr_setup", paddr, 32'h30);
    @(negedge pclk);
    chk("busy_access", {psel, penable}, 2'b11);
    chk("busy_paddr_access", paddr, 32'h30);
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    chk("rst_mid_bus", {psel, penable, pwrite}, 3'b000);
    chk("rst_mid_rsp", rsp_valid, 0);
    chk("rst_mid_paddr", paddr, 0);
    preset = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
    pready = 1'b1; pslverr = 1'b0; prdata = 8'h55;
    chk("held_accept_setup", {psel, penable}, 2'b10);
    chk("held_accept_paddr", paddr, 32'h44);
    chk("held_accept_wdata", {pwrite, pwdata}, {1'b1, 8'h3C});
    @(negedge pclk);
    @(negedge pclk);
    chk("held_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 8'h00});
    pready = 1'b0;

    // Back-to-back: next command accepted in the rsp_valid cycle.
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 8'h11;
    @(negedge pclk);
    cmd_write = 1'b0; cmd_addr = 32'h61; cmd_wdata = 8'h00;
    pready = 1'b1; pslverr = 1'b0; prdata = 8'h22;
    @(negedge pclk);
    chk("b2b_first_access", {psel, penable, paddr}, {2'b11, 32'h60});
    @(negedge pclk);
    chk("b2b_first_rsp", {rsp_valid, cmd_ready, rsp_err, rsp_rdata}, {3'b110, 8'h00});
    @(negedge pclk);
    cmd_valid = 1'b0;
    chk("b2b_second_setup", {psel, penable, pwrite, paddr}, {3'b100, 32'h61});
    @(negedge pclk);
    @(negedge pclk);
    chk("b2b_second_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 8'h22});
    pready = 1'b0;
    @(negedge pclk);
    chk("b2b_idle", {psel, rsp_valid, cmd_ready}, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
